// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports A/B plus the memory-side bus of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ready;
    logic [DATA_W-1:0] a_rdata;
    logic              a_stall;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ready;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ready, a_rdata, a_stall,
        output b_ready, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    // Requester and memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ready, a_rdata, a_stall,
        input  b_ready, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win last time is chosen.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);

    // Grant selection
    always_comb begin
        valid_o = a_req_i | b_req_i;
        if (a_req_i && b_req_i) begin
            grant_o = (last_grant_i == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req_i) begin
            grant_o = PORT_B;
        end else begin
            grant_o = PORT_A;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between a CPU port (A) and a loader/debug port (B).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be >= 1");
    end

    localparam int                CNT_W    = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q,      state_d;
    logic              gnt_q,        gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] a_rdata_q,    a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,    b_rdata_d;
    logic              a_ready_q,    a_ready_d;
    logic              b_ready_q,    b_ready_d;

    logic              pick_valid_s;
    logic              pick_port_s;

    rr_arbiter2 u_rr (
        .a_req_i      (bus.a_req),
        .b_req_i      (bus.b_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid_s),
        .grant_o      (pick_port_s)
    );

    // State and data registers; reset aborts any transaction without a ready pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= PORT_A;
            last_grant_q <= PORT_B;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            a_ready_q    <= a_ready_d;
            b_ready_q    <= b_ready_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        a_ready_d    = 1'b0;
        b_ready_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d      = BUSY;
                    gnt_d        = pick_port_s;
                    last_grant_d = pick_port_s;
                    cnt_d        = CNT_INIT;
                    mem_en_d     = 1'b1;
                    if (pick_port_s == PORT_B) begin
                        mem_we_d    = bus.b_we;
                        mem_addr_d  = bus.b_addr;
                        mem_wdata_d = bus.b_wdata;
                    end else begin
                        mem_we_d    = bus.a_we;
                        mem_addr_d  = bus.a_addr;
                        mem_wdata_d = bus.a_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Ready is registered here so it appears during RESP
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (gnt_q == PORT_B) begin
                        b_rdata_d = bus.mem_rdata;
                        b_ready_d = 1'b1;
                    end else begin
                        a_rdata_d = bus.mem_rdata;
                        a_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.a_ready   = a_ready_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_ready   = b_ready_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.a_stall   = bus.a_req & ~a_ready_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
